// File: rtl/cpu_writeback_unit.sv
// Writeback stage driving the register file write port: merges ALU and buffered load results.
// Optional macro WRITEBACK_BYPASS_EN adds a combinational bypass lookup over FIFO and write stage.
module cpu_writeback_unit #(
    parameter int unsigned NUMBER_OF_REGISTERS = 256,
    parameter int unsigned DATA_WIDTH          = 8,
    parameter int unsigned FIFO_DEPTH          = 4,
    localparam int unsigned ADDR_W             = $clog2(NUMBER_OF_REGISTERS),
    localparam int unsigned CNT_W              = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clock_in,
    input  logic                  reset_n_in,
    input  logic                  alu_valid_in,
    output logic                  alu_ready_out,
    input  logic [ADDR_W-1:0]     alu_address_in,
    input  logic [DATA_WIDTH-1:0] alu_data_in,
    input  logic                  load_valid_in,
    output logic                  load_ready_out,
    input  logic [ADDR_W-1:0]     load_address_in,
    input  logic [DATA_WIDTH-1:0] load_data_in,
    output logic                  write_enable_out,
    output logic [ADDR_W-1:0]     write_register_address_out,
    output logic [DATA_WIDTH-1:0] write_data_out,
    output logic [CNT_W-1:0]      pending_count_out,
    output logic [7:0]            r0_drop_count_out
`ifdef WRITEBACK_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0]     bypass_query_address_in,
    output logic                  bypass_hit_out,
    output logic [DATA_WIDTH-1:0] bypass_data_out
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic [ADDR_W-1:0]     fifo_addr_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]      fifo_count_q;

    logic                  full, empty;
    logic                  push, alu_win, fifo_win, win_valid;
    logic [ADDR_W-1:0]     win_addr;
    logic [DATA_WIDTH-1:0] win_data;

    always_comb begin
        full           = (fifo_count_q == CNT_W'(FIFO_DEPTH));
        empty          = (fifo_count_q == '0);
        alu_ready_out  = reset_n_in && !full;
        load_ready_out = reset_n_in && !full;
        push           = load_valid_in && load_ready_out;
        alu_win        = alu_valid_in && alu_ready_out;
        // A full FIFO always drains its head so the ALU path cannot starve it indefinitely.
        fifo_win       = reset_n_in && !empty && (full || !alu_valid_in);
        win_valid      = alu_win || fifo_win;
        win_addr       = alu_win ? alu_address_in : fifo_addr_mem[rd_ptr_q];
        win_data       = alu_win ? alu_data_in    : fifo_data_mem[rd_ptr_q];
    end

    always_ff @(posedge clock_in) begin
        if (push) begin
            fifo_addr_mem[wr_ptr_q] <= load_address_in;
            fifo_data_mem[wr_ptr_q] <= load_data_in;
        end
    end

    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            rd_ptr_q                   <= '0;
            wr_ptr_q                   <= '0;
            fifo_count_q               <= '0;
            write_enable_out           <= 1'b0;
            write_register_address_out <= '0;
            write_data_out             <= '0;
            r0_drop_count_out          <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (fifo_win) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            fifo_count_q     <= fifo_count_q + CNT_W'(push) - CNT_W'(fifo_win);
            write_enable_out <= win_valid && (win_addr != '0);
            if (win_valid && (win_addr != '0)) begin
                write_register_address_out <= win_addr;
                write_data_out             <= win_data;
            end
            if (win_valid && (win_addr == '0) && (r0_drop_count_out != 8'hFF)) begin
                r0_drop_count_out <= r0_drop_count_out + 8'd1;
            end
        end
    end

    assign pending_count_out = fifo_count_q;

`ifdef WRITEBACK_BYPASS_EN
    logic [PTR_W-1:0] scan_idx;

    // Scan oldest to newest so the youngest matching entry overrides earlier ones.
    always_comb begin
        bypass_hit_out  = 1'b0;
        bypass_data_out = '0;
        scan_idx        = '0;
        if (write_enable_out && (write_register_address_out == bypass_query_address_in)) begin
            bypass_hit_out  = 1'b1;
            bypass_data_out = write_data_out;
        end
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            scan_idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < fifo_count_q) &&
                (fifo_addr_mem[scan_idx] == bypass_query_address_in)) begin
                bypass_hit_out  = 1'b1;
                bypass_data_out = fifo_data_mem[scan_idx];
            end
        end
        if (bypass_query_address_in == '0) begin
            bypass_hit_out  = 1'b0;
            bypass_data_out = '0;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_writeback_unit.sv
// Table-driven bench for cpu_writeback_unit; bypass checks compile only with WRITEBACK_BYPASS_EN.
module tb_cpu_writeback_unit;

    logic       clk;
    logic       rst_n;
    logic       alu_v, load_v;
    logic       alu_rdy, load_rdy;
    logic [7:0] alu_a, alu_d, load_a, load_d;
    logic       we;
    logic [7:0] wa, wd;
    logic [2:0] pend;
    logic [7:0] drop;
`ifdef WRITEBACK_BYPASS_EN
    logic [7:0] bq;
    logic       bhit;
    logic [7:0] bdata;
`endif

    int errors = 0;
    int checks = 0;

    cpu_writeback_unit dut (
        .clock_in                   (clk),
        .reset_n_in                 (rst_n),
        .alu_valid_in               (alu_v),
        .alu_ready_out              (alu_rdy),
        .alu_address_in             (alu_a),
        .alu_data_in                (alu_d),
        .load_valid_in              (load_v),
        .load_ready_out             (load_rdy),
        .load_address_in            (load_a),
        .load_data_in               (load_d),
        .write_enable_out           (we),
        .write_register_address_out (wa),
        .write_data_out             (wd),
        .pending_count_out          (pend),
        .r0_drop_count_out          (drop)
`ifdef WRITEBACK_BYPASS_EN
        ,
        .bypass_query_address_in    (bq),
        .bypass_hit_out             (bhit),
        .bypass_data_out            (bdata)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       alu_v;
        logic [7:0] alu_a;
        logic [7:0] alu_d;
        logic       load_v;
        logic [7:0] load_a;
        logic [7:0] load_d;
        logic       rdy;
        logic       we;
        logic [7:0] wa;
        logic [7:0] wd;
        logic [2:0] pend;
        logic [7:0] drop;
    } vec_t;

    vec_t vecs [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [7:0] aa, input logic [7:0] ad,
                         input logic lv, input logic [7:0] la, input logic [7:0] ld);
        alu_v  = av;
        alu_a  = aa;
        alu_d  = ad;
        load_v = lv;
        load_a = la;
        load_d = ld;
    endtask

    initial begin
        logic we_seen;
        vecs[0]  = '{1'b1, 8'd5,  8'hA5, 1'b0, 8'd0, 8'h00, 1'b1, 1'b1, 8'd5,  8'hA5, 3'd0, 8'd0};
        vecs[1]  = '{1'b1, 8'd3,  8'h11, 1'b1, 8'd4, 8'h22, 1'b1, 1'b1, 8'd3,  8'h11, 3'd1, 8'd0};
        vecs[2]  = '{1'b0, 8'd0,  8'h00, 1'b0, 8'd0, 8'h00, 1'b1, 1'b1, 8'd4,  8'h22, 3'd0, 8'd0};
        vecs[3]  = '{1'b0, 8'd0,  8'h00, 1'b0, 8'd0, 8'h00, 1'b1, 1'b0, 8'd4,  8'h22, 3'd0, 8'd0};
        vecs[4]  = '{1'b1, 8'd9,  8'h90, 1'b1, 8'd1, 8'h01, 1'b1, 1'b1, 8'd9,  8'h90, 3'd1, 8'd0};
        vecs[5]  = '{1'b1, 8'd10, 8'h91, 1'b1, 8'd2, 8'h02, 1'b1, 1'b1, 8'd10, 8'h91, 3'd2, 8'd0};
        vecs[6]  = '{1'b1, 8'd11, 8'h92, 1'b1, 8'd3, 8'h03, 1'b1, 1'b1, 8'd11, 8'h92, 3'd3, 8'd0};
        vecs[7]  = '{1'b1, 8'd12, 8'h93, 1'b1, 8'd4, 8'h04, 1'b1, 1'b1, 8'd12, 8'h93, 3'd4, 8'd0};
        vecs[8]  = '{1'b1, 8'd13, 8'h94, 1'b1, 8'd5, 8'h05, 1'b0, 1'b1, 8'd1,  8'h01, 3'd3, 8'd0};
        vecs[9]  = '{1'b1, 8'd13, 8'h94, 1'b0, 8'd0, 8'h00, 1'b1, 1'b1, 8'd13, 8'h94, 3'd3, 8'd0};
        vecs[10] = '{1'b0, 8'd0,  8'h00, 1'b0, 8'd0, 8'h00, 1'b1, 1'b1, 8'd2,  8'h02, 3'd2, 8'd0};
        vecs[11] = '{1'b0, 8'd0,  8'h00, 1'b0, 8'd0, 8'h00, 1'b1, 1'b1, 8'd3,  8'h03, 3'd1, 8'd0};
        vecs[12] = '{1'b0, 8'd0,  8'h00, 1'b0, 8'd0, 8'h00, 1'b1, 1'b1, 8'd4,  8'h04, 3'd0, 8'd0};
        vecs[13] = '{1'b0, 8'd0,  8'h00, 1'b1, 8'd0, 8'h77, 1'b1, 1'b0, 8'd4,  8'h04, 3'd1, 8'd0};
        vecs[14] = '{1'b0, 8'd0,  8'h00, 1'b0, 8'd0, 8'h00, 1'b1, 1'b0, 8'd4,  8'h04, 3'd0, 8'd1};
        vecs[15] = '{1'b1, 8'd0,  8'hEE, 1'b0, 8'd0, 8'h00, 1'b1, 1'b0, 8'd4,  8'h04, 3'd0, 8'd2};
        vecs[16] = '{1'b0, 8'd0,  8'h00, 1'b1, 8'd6, 8'h66, 1'b1, 1'b0, 8'd4,  8'h04, 3'd1, 8'd2};
        vecs[17] = '{1'b0, 8'd0,  8'h00, 1'b1, 8'd7, 8'h67, 1'b1, 1'b1, 8'd6,  8'h66, 3'd1, 8'd2};
        vecs[18] = '{1'b0, 8'd0,  8'h00, 1'b0, 8'd0, 8'h00, 1'b1, 1'b1, 8'd7,  8'h67, 3'd0, 8'd2};

`ifdef WRITEBACK_BYPASS_EN
        bq = 8'd0;
`endif
        // Reset held for two cycles with both valids asserted.
        rst_n = 1'b0;
        drive(1'b1, 8'd5, 8'h55, 1'b1, 8'd6, 8'h66);
        #1;
        chk("reset_alu_ready", 32'(alu_rdy), 32'd0);
        chk("reset_load_ready", 32'(load_rdy), 32'd0);
        step();
        step();
        chk("reset_we", 32'(we), 32'd0);
        chk("reset_addr", 32'(wa), 32'd0);
        chk("reset_data", 32'(wd), 32'd0);
        chk("reset_pending", 32'(pend), 32'd0);
        chk("reset_drop", 32'(drop), 32'd0);
        chk("reset_alu_ready_held", 32'(alu_rdy), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].alu_v, vecs[i].alu_a, vecs[i].alu_d,
                  vecs[i].load_v, vecs[i].load_a, vecs[i].load_d);
            #1;
            chk($sformatf("v%0d_alu_ready", i), 32'(alu_rdy), 32'(vecs[i].rdy));
            chk($sformatf("v%0d_load_ready", i), 32'(load_rdy), 32'(vecs[i].rdy));
            step();
            chk($sformatf("v%0d_we", i), 32'(we), 32'(vecs[i].we));
            chk($sformatf("v%0d_addr", i), 32'(wa), 32'(vecs[i].wa));
            chk($sformatf("v%0d_data", i), 32'(wd), 32'(vecs[i].wd));
            chk($sformatf("v%0d_pending", i), 32'(pend), 32'(vecs[i].pend));
            chk($sformatf("v%0d_drop", i), 32'(drop), 32'(vecs[i].drop));
        end

        // Reset in the middle of queued loads: contents lost, nothing written afterwards.
        drive(1'b1, 8'd20, 8'h30, 1'b1, 8'd8, 8'h08);
        step();
        drive(1'b1, 8'd21, 8'h31, 1'b1, 8'd9, 8'h09);
        step();
        chk("midrst_pending_before", 32'(pend), 32'd2);
        rst_n = 1'b0;
        drive(1'b0, 8'd0, 8'h00, 1'b0, 8'd0, 8'h00);
        #1;
        chk("midrst_load_ready", 32'(load_rdy), 32'd0);
        step();
        chk("midrst_pending", 32'(pend), 32'd0);
        chk("midrst_we", 32'(we), 32'd0);
        chk("midrst_drop", 32'(drop), 32'd0);
        rst_n = 1'b1;
        step();
        chk("midrst_no_write_after", 32'(we), 32'd0);
        chk("midrst_pending_after", 32'(pend), 32'd0);

        // ALU writes to r0 are swallowed; drop counter saturates at 255.
        we_seen = 1'b0;
        drive(1'b1, 8'd0, 8'hFF, 1'b0, 8'd0, 8'h00);
        for (int i = 1; i <= 300; i++) begin
            step();
            if (we) we_seen = 1'b1;
            if (i == 254) chk("r0_drop_254", 32'(drop), 32'd254);
            if (i == 255) chk("r0_drop_255", 32'(drop), 32'd255);
        end
        chk("r0_never_written", 32'(we_seen), 32'd0);
        chk("r0_drop_saturated", 32'(drop), 32'd255);

`ifdef WRITEBACK_BYPASS_EN
        // Two loads to r7 queue up behind a busy ALU; the newer one must be returned.
        drive(1'b1, 8'd20, 8'h30, 1'b1, 8'd7, 8'h01);
        step();
        drive(1'b1, 8'd21, 8'h31, 1'b1, 8'd7, 8'h02);
        step();
        drive(1'b1, 8'd22, 8'h32, 1'b0, 8'd0, 8'h00);
        bq = 8'd7;
        #1;
        chk("bypass_r7_hit", 32'(bhit), 32'd1);
        chk("bypass_r7_data", 32'(bdata), 32'h02);
        bq = 8'd21;
        #1;
        chk("bypass_wstage_hit", 32'(bhit), 32'd1);
        chk("bypass_wstage_data", 32'(bdata), 32'h31);
        bq = 8'd0;
        #1;
        chk("bypass_r0_hit", 32'(bhit), 32'd0);
        chk("bypass_r0_data", 32'(bdata), 32'h00);
        bq = 8'd99;
        #1;
        chk("bypass_miss_hit", 32'(bhit), 32'd0);
        chk("bypass_miss_data", 32'(bdata), 32'h00);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
